// File: rtl/mra_frame_reader_if.sv
// AXI4 read address/data channels between the MRA frame reader (master) and DRAM (slave).
interface mra_frame_reader_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
);
  logic [ID_WIDTH-1:0]   arid_m_inf;
  logic [ADDR_WIDTH-1:0] araddr_m_inf;
  logic [7:0]            arlen_m_inf;
  logic [2:0]            arsize_m_inf;
  logic [1:0]            arburst_m_inf;
  logic                  arvalid_m_inf;
  logic                  arready_m_inf;
  logic [ID_WIDTH-1:0]   rid_m_inf;
  logic [1:0]            rresp_m_inf;
  logic [DATA_WIDTH-1:0] rdata_m_inf;
  logic                  rlast_m_inf;
  logic                  rvalid_m_inf;
  logic                  rready_m_inf;

  modport master (
    output arid_m_inf, araddr_m_inf, arlen_m_inf, arsize_m_inf, arburst_m_inf, arvalid_m_inf,
    input  arready_m_inf,
    input  rid_m_inf, rresp_m_inf, rdata_m_inf, rlast_m_inf, rvalid_m_inf,
    output rready_m_inf
  );

  modport slave (
    input  arid_m_inf, araddr_m_inf, arlen_m_inf, arsize_m_inf, arburst_m_inf, arvalid_m_inf,
    output arready_m_inf,
    output rid_m_inf, rresp_m_inf, rdata_m_inf, rlast_m_inf, rvalid_m_inf,
    input  rready_m_inf
  );
endinterface

// File: rtl/mra_frame_reader.sv
// Fetches one 2 KB location-map frame as a single 128-beat AXI4 INCR burst and
// forwards each beat, tagged with its row index, through a 1-entry output register.
module mra_frame_reader #(
  parameter int                    ID_WIDTH   = 4,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 128,
  parameter logic [ADDR_WIDTH-1:0] MAP_BASE   = 32'h0001_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4:0]            frame_id,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  mra_frame_reader_if.master    axi,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [6:0]            out_addr,
  output logic [DATA_WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_AR    = 2'd1,
    S_DATA  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [4:0]            frame_q;
  logic [6:0]            cnt_q;
  logic                  err_q;
  logic                  done_q;
  logic                  out_valid_q;
  logic [6:0]            out_addr_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  logic rready_s;
  logic arvalid_s;
  logic start_acc_s;
  logic r_take_s;
  logic final_s;
  logic beat_bad_s;
  logic out_pop_s;
  logic drain_exit_s;

  assign start_acc_s  = (state_q == S_IDLE) && start;
  assign r_take_s     = axi.rvalid_m_inf && rready_s;
  assign final_s      = r_take_s && ((cnt_q == 7'd127) || axi.rlast_m_inf);
  // rlast must coincide exactly with row 127; either side of that is a protocol error.
  assign beat_bad_s   = (axi.rresp_m_inf != 2'b00) || (axi.rid_m_inf != {ID_WIDTH{1'b0}}) ||
                        (axi.rlast_m_inf != (cnt_q == 7'd127));
  assign out_pop_s    = out_valid_q && out_ready;
  assign drain_exit_s = (state_q == S_DRAIN) && (out_pop_s || !out_valid_q);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_AR; else state_d = S_IDLE;
      S_AR:    if (axi.arvalid_m_inf && axi.arready_m_inf) state_d = S_DATA; else state_d = S_AR;
      S_DATA:  if (final_s) state_d = S_DRAIN; else state_d = S_DATA;
      S_DRAIN: if (drain_exit_s) state_d = S_IDLE; else state_d = S_DRAIN;
      default: state_d = S_IDLE;
    endcase
  end

  // Channel handshake outputs decoded from state.
  always_comb begin
    arvalid_s = 1'b0;
    rready_s  = 1'b0;
    case (state_q)
      S_AR:    arvalid_s = 1'b1;
      S_DATA:  rready_s  = !out_valid_q || out_ready;
      default: begin
        arvalid_s = 1'b0;
        rready_s  = 1'b0;
      end
    endcase
  end

  // Transaction bookkeeping and the 1-entry output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q     <= 5'd0;
      cnt_q       <= 7'd0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_addr_q  <= 7'd0;
      out_data_q  <= {DATA_WIDTH{1'b0}};
    end else begin
      done_q <= drain_exit_s;
      if (start_acc_s) begin
        frame_q <= frame_id;
        err_q   <= 1'b0;
        cnt_q   <= 7'd0;
      end else if (r_take_s) begin
        if (beat_bad_s) err_q <= 1'b1;
        if (!final_s) cnt_q <= cnt_q + 7'd1;
      end
      // A reload in the same cycle as a pop keeps the register full.
      if (r_take_s) begin
        out_valid_q <= 1'b1;
        out_addr_q  <= cnt_q;
        out_data_q  <= axi.rdata_m_inf;
      end else if (out_pop_s) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign axi.arid_m_inf    = {ID_WIDTH{1'b0}};
  assign axi.araddr_m_inf  = MAP_BASE + ADDR_WIDTH'({frame_q, 11'h000});
  assign axi.arlen_m_inf   = 8'd127;
  assign axi.arsize_m_inf  = 3'b100;
  assign axi.arburst_m_inf = 2'b01;
  assign axi.arvalid_m_inf = arvalid_s;
  assign axi.rready_m_inf  = rready_s;

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_mra_frame_reader.sv
// Randomized bench for mra_frame_reader: a bench-side AXI slave serves frames while a
// frame-level model predicts the beat stream, done pulse and error flag.
module tb_mra_frame_reader;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [4:0]    frame_id = 5'd0;
  logic          busy, done, err, out_valid;
  logic          out_ready = 1'b0;
  logic [6:0]    out_addr;
  logic [DW-1:0] out_data;

  mra_frame_reader_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(DW)) axi ();

  mra_frame_reader dut (
    .clk(clk), .rst(rst), .start(start), .frame_id(frame_id),
    .busy(busy), .done(done), .err(err), .axi(axi),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Frame-level model: beat payloads, number of rows that must emerge, error outcome, address.
  logic [DW-1:0] beat_mem [0:129];
  int            exp_n = 128;
  bit            exp_err = 1'b0;
  logic [31:0]   exp_araddr = 32'h0;

  // Owned by the compare process.
  int pos = 0;
  int done_cnt = 0;
  bit final_hs_prev = 1'b0;
  bit start_prev = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Per-cycle compare of DUT outputs against the model.
  always @(negedge clk) begin
    if (rst) begin
      pos = 0;
      final_hs_prev = 1'b0;
      start_prev = 1'b0;
    end else begin
      if (start_prev) begin
        pos = 0;
        check("busy_after_start", 128'(busy), 128'(1));
        check("err_cleared", 128'(err), 128'(0));
      end
      check("done_timing", 128'(done), 128'(final_hs_prev));
      if (done) begin
        done_cnt++;
        check("err_at_done", 128'(err), 128'(exp_err));
        check("busy_at_done", 128'(busy), 128'(0));
      end
      if (axi.arvalid_m_inf) begin
        check("araddr", 128'(axi.araddr_m_inf), 128'(exp_araddr));
        check("arlen", 128'(axi.arlen_m_inf), 128'(127));
        check("arsize", 128'(axi.arsize_m_inf), 128'(4));
        check("arburst", 128'(axi.arburst_m_inf), 128'(1));
        check("arid", 128'(axi.arid_m_inf), 128'(0));
      end
      if (axi.arvalid_m_inf || axi.rready_m_inf || out_valid)
        check("busy_active", 128'(busy), 128'(1));
      final_hs_prev = 1'b0;
      if (out_valid && out_ready) begin
        if (pos < exp_n) begin
          check("out_addr", 128'(out_addr), 128'(pos));
          check("out_data", out_data, beat_mem[pos]);
        end else begin
          check("extra_beat", 128'(pos), 128'(exp_n));
        end
        final_hs_prev = (pos == exp_n - 1);
        pos++;
      end
      start_prev = start && !busy;
    end
  end

  task automatic check_reset_vals();
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    check("rst_arvalid", 128'(axi.arvalid_m_inf), 128'(0));
    check("rst_rready", 128'(axi.rready_m_inf), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_addr", 128'(out_addr), 128'(0));
    check("rst_out_data", out_data, 128'(0));
  endtask

  task automatic idle_bus();
    axi.arready_m_inf = 1'b0;
    axi.rvalid_m_inf  = 1'b0;
    axi.rlast_m_inf   = 1'b0;
    axi.rresp_m_inf   = 2'b00;
    axi.rid_m_inf     = 4'd0;
    axi.rdata_m_inf   = '0;
  endtask

  // One frame fetch. ready_mode: 0 always ready, 1 toggling, 2 random.
  // last_beat: index carrying rlast (-1 none); avail: beats the slave offers; rst_beat: -1 none.
  task automatic run_txn(input int fid, input int ar_delay, input int ready_mode,
                         input int bad_beat, input int last_beat, input int avail,
                         input int rst_beat, input logic [31:0] lit_addr,
                         input int lit_beats, input bit lit_err);
    int beat, ar_cycles, cyc, done0;
    bit ar_done, ar_hs, r_hs, done_seen;
    logic [31:0] cap_addr;
    for (int i = 0; i < 130; i++)
      beat_mem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp_n      = (last_beat >= 0 && last_beat < 127) ? last_beat + 1 : 128;
    exp_err    = (bad_beat >= 0 && bad_beat < exp_n) || (last_beat != 127);
    exp_araddr = 32'h0001_0000 + 32'(fid) * 32'h800;
    done0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; frame_id = 5'(fid);
    @(posedge clk); #1;
    start = 1'b0; frame_id = 5'($urandom_range(0, 31));
    beat = 0; ar_cycles = 0; cyc = 0; ar_done = 1'b0; done_seen = 1'b0; cap_addr = 32'h0;
    axi.arready_m_inf = (ar_delay == 0);
    out_ready = (ready_mode == 0) ? 1'b1 : 1'(ready_mode == 2 ? $urandom_range(0, 1) : 0);
    while (!done_seen && cyc < 3000) begin
      @(negedge clk);
      ar_hs = axi.arvalid_m_inf && axi.arready_m_inf;
      r_hs  = axi.rvalid_m_inf && axi.rready_m_inf;
      if (done) done_seen = 1'b1;
      if (axi.arvalid_m_inf) begin
        if (ar_cycles == 0) cap_addr = axi.araddr_m_inf;
        ar_cycles++;
      end
      if (rst_beat >= 0 && beat == rst_beat) break;
      @(posedge clk); #1;
      if (ar_hs) ar_done = 1'b1;
      if (r_hs) beat++;
      axi.arready_m_inf = !ar_done && (ar_cycles >= ar_delay);
      axi.rvalid_m_inf  = ar_done && (beat < avail);
      axi.rdata_m_inf   = (beat < avail) ? beat_mem[beat] : '0;
      axi.rlast_m_inf   = (beat == last_beat);
      axi.rresp_m_inf   = (beat == bad_beat) ? 2'b10 : 2'b00;
      axi.rid_m_inf     = 4'd0;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = cyc[0];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      cyc++;
    end
    check("ar_addr_literal", 128'(cap_addr), 128'(lit_addr));
    if (rst_beat >= 0) begin
      @(posedge clk); #1;
      rst = 1'b1;
      idle_bus();
      @(negedge clk);
      check_reset_vals();
      @(posedge clk); #1;
      rst = 1'b0;
    end else begin
      if (!done_seen) begin
        checks++; errors++;
        $display("FAIL timeout: done not seen after %0d cycles", cyc);
      end
      check("beats_out", 128'(pos), 128'(lit_beats));
      check("err_end", 128'(err), 128'(lit_err));
      if (ar_delay > 0) check("ar_hold_cycles", 128'(ar_cycles), 128'(ar_delay + 1));
      idle_bus();
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("done_pulses", 128'(done_cnt - done0), 128'(1));
    end
  endtask

  initial begin
    idle_bus();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    rst = 1'b0;

    run_txn(0,  0, 0, -1, 127, 128, -1, 32'h0001_0000, 128, 1'b0);
    run_txn(31, 5, 0, -1, 127, 128, -1, 32'h0001_F800, 128, 1'b0);
    run_txn(7,  0, 1, -1, 127, 128, -1, 32'h0001_3800, 128, 1'b0);
    run_txn(3,  2, 0, 40, 127, 128, -1, 32'h0001_1800, 128, 1'b1);
    run_txn(12, 0, 2, -1, 127, 128, -1, 32'h0001_6000, 128, 1'b0);
    run_txn(9,  1, 0, -1, 99,  128, -1, 32'h0001_4800, 100, 1'b1);
    run_txn(20, 0, 2, -1, -1,  130, -1, 32'h0001_A000, 128, 1'b1);
    run_txn(5,  0, 2, -1, 127, 128, 60, 32'h0001_2800, 0,   1'b0);
    run_txn(1,  0, 0, -1, 127, 128, -1, 32'h0001_0800, 128, 1'b0);
    for (int k = 0; k < 4; k++) begin
      int f;
      f = $urandom_range(0, 31);
      run_txn(f, $urandom_range(0, 4), 2, -1, 127, 128, -1,
              32'h0001_0000 + 32'(f) * 32'h800, 128, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
